serial_right_shifter: RTL and testbench

SERIAL_RIGHT_SHIFTER -- requirements
Module: serial_right_shifter

---
 rtl/serial_right_shifter.sv | 85 ++++++++
 tb/tb_serial_right_shifter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_right_shifter.sv
// Multi-cycle logical right shifter: one bit per clock, done pulse on completion.
// Define SHIFTER_STICKY_BIT_EN to add the sticky output (OR of all bits shifted out).
module serial_right_shifter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [4:0]            shift_amt,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [4:0]            shift_count
`ifdef SHIFTER_STICKY_BIT_EN
  ,
  output logic                  sticky
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]            state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [4:0]            amt_q;
  logic [4:0]            count_q;
  logic                  more;

  // count_q only increments while below amt_q (<= 31), so it cannot wrap
  assign more = (count_q < amt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      amt_q   <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            data_q  <= data_in;
            amt_q   <= shift_amt;
            count_q <= '0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (more) begin
            data_q  <= {1'b0, data_q[DATA_WIDTH-1:1]};
            count_q <= count_q + 5'd1;
          end else begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SHIFTER_STICKY_BIT_EN
  logic sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      sticky_q <= 1'b0;
    end else if (state_q == ST_SHIFT && more) begin
      sticky_q <= sticky_q | data_q[0];
    end
  end

  assign sticky = sticky_q;
`endif

  assign busy        = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign done        = (state_q == ST_DONE);
  assign data_out    = data_q;
  assign shift_count = count_q;

endmodule

// File: tb/tb_serial_right_shifter.sv
// Directed bench for serial_right_shifter: 32-bit and 16-bit instances,
// vector table plus hand-written restart-ignore and mid-run reset sequences.
module tb_serial_right_shifter;

  logic        clk;
  logic        rst_n;
  logic        start32, start16;
  logic [31:0] din32;
  logic [15:0] din16;
  logic [4:0]  amt32, amt16;
  logic        busy32, busy16, done32, done16;
  logic [31:0] dout32;
  logic [15:0] dout16;
  logic [4:0]  cnt32, cnt16;
`ifdef SHIFTER_STICKY_BIT_EN
  logic        sticky32, sticky16;
`endif

  int passed = 0;
  int total  = 0;

  serial_right_shifter #(.DATA_WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .data_in(din32), .shift_amt(amt32),
    .busy(busy32), .done(done32), .data_out(dout32), .shift_count(cnt32)
`ifdef SHIFTER_STICKY_BIT_EN
    , .sticky(sticky32)
`endif
  );

  serial_right_shifter #(.DATA_WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .data_in(din16), .shift_amt(amt16),
    .busy(busy16), .done(done16), .data_out(dout16), .shift_count(cnt16)
`ifdef SHIFTER_STICKY_BIT_EN
    , .sticky(sticky16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel16;
    logic [31:0] din;
    logic [4:0]  amt;
    logic [31:0] exp_out;
    logic [4:0]  exp_cnt;
    int          exp_lat;
    logic        exp_sticky;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] rd_out(input logic sel16);
    return sel16 ? {16'h0, dout16} : dout32;
  endfunction

  function automatic logic rd_done(input logic sel16);
    return sel16 ? done16 : done32;
  endfunction

  function automatic logic rd_busy(input logic sel16);
    return sel16 ? busy16 : busy32;
  endfunction

  function automatic logic [4:0] rd_cnt(input logic sel16);
    return sel16 ? cnt16 : cnt32;
  endfunction

  // Called 1 time unit after a rising edge; returns in the same phase.
  task automatic run_op(input vec_t v, input string name);
    int lat;
    bit seen;
    if (v.sel16) begin
      din16 = v.din[15:0]; amt16 = v.amt; start16 = 1'b1;
    end else begin
      din32 = v.din; amt32 = v.amt; start32 = 1'b1;
    end
    @(posedge clk); #1;
    start32 = 1'b0; start16 = 1'b0;
    din32 = ~v.din; din16 = ~v.din[15:0];
    amt32 = ~v.amt; amt16 = ~v.amt;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(posedge clk); #1;
      if (rd_done(v.sel16)) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    chk({name, " latency"}, lat, v.exp_lat);
    chk({name, " data_out"}, rd_out(v.sel16), v.exp_out);
    chk({name, " shift_count"}, {27'd0, rd_cnt(v.sel16)}, {27'd0, v.exp_cnt});
`ifdef SHIFTER_STICKY_BIT_EN
    chk({name, " sticky"}, {31'd0, (v.sel16 ? sticky16 : sticky32)}, {31'd0, v.exp_sticky});
`endif
    @(posedge clk); #1;
    chk({name, " done one cycle"}, {30'd0, rd_done(v.sel16), rd_busy(v.sel16)}, 32'd0);
  endtask

  initial begin
    int busy_cyc, done_cnt;
    vec_t v;

    rst_n = 1'b0;
    start32 = 1'b0; start16 = 1'b0;
    din32 = '0; din16 = '0; amt32 = '0; amt16 = '0;

    vecs[0] = '{1'b0, 32'h8000_0001,  5'd4, 32'h0800_0000,  5'd4,  5, 1'b1};
    vecs[1] = '{1'b0, 32'hDEAD_BEEF,  5'd0, 32'hDEAD_BEEF,  5'd0,  1, 1'b0};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 5'd31, 32, 1'b1};
    vecs[3] = '{1'b0, 32'h1234_5678, 5'd16, 32'h0000_1234, 5'd16, 17, 1'b1};
    vecs[4] = '{1'b0, 32'h0000_0100,  5'd8, 32'h0000_0001,  5'd8,  9, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_ABCD, 5'd20, 32'h0000_0000, 5'd20, 21, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_8000, 5'd15, 32'h0000_0001, 5'd15, 16, 1'b0};

    #12;
    chk("reset data_out", dout32, 32'h0);
    chk("reset shift_count", {27'd0, cnt32}, 32'd0);
    chk("reset busy/done", {30'd0, busy32, done32}, 32'd0);
    chk("reset 16b data_out", {16'h0, dout16}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Results hold in IDLE while inputs wander and start stays low
    din32 = 32'h5555_AAAA; amt32 = 5'd3;
    repeat (4) @(posedge clk);
    #1;
    chk("idle hold data_out", dout32, 32'h0000_0001);
    chk("idle hold shift_count", {27'd0, cnt32}, 32'd8);

    // Restarts during SHIFT and DONE are ignored
    din32 = 32'hA5A5_A5A5; amt32 = 5'd8; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    busy_cyc = (busy32 && !done32) ? 1 : 0;
    done_cnt = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (busy32 && !done32) busy_cyc++;
      if (done32) begin
        done_cnt++;
        chk("restart busy in done", {31'd0, busy32}, 32'd1);
        chk("restart data at done", dout32, 32'h00A5_A5A5);
      end
      if (k == 2 || done32) begin
        start32 = 1'b1; din32 = 32'hFFFF_FFFF; amt32 = 5'd2;
      end else begin
        start32 = 1'b0;
      end
    end
    chk("restart done pulses", done_cnt, 32'd1);
    chk("restart busy before done", busy_cyc, 32'd9);
    chk("restart final data", dout32, 32'h00A5_A5A5);
    chk("restart final count", {27'd0, cnt32}, 32'd8);

    // Mid-run asynchronous reset aborts without done
    din32 = 32'hFFFF_0000; amt32 = 5'd10; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async reset data_out", dout32, 32'h0);
    chk("async reset count", {27'd0, cnt32}, 32'd0);
    chk("async reset busy/done", {30'd0, busy32, done32}, 32'd0);
`ifdef SHIFTER_STICKY_BIT_EN
    chk("async reset sticky", {31'd0, sticky32}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done32 || busy32) done_cnt++;
    end
    chk("no activity after abort", done_cnt, 32'd0);

    v = '{1'b0, 32'h0000_00F0, 5'd4, 32'h0000_000F, 5'd4, 5, 1'b0};
    run_op(v, "post-reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
